// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// fifo_arb_pkg : op encoding and sizing helpers shared by fifo_share_arbiter
// Revision     : 1.0
// ============================================================================
package fifo_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int DEPTH_DEF = 8;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick  : combinational round-robin picker, first request at/after ptr_i
// Revision : 1.0
// ============================================================================
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0] w_pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    w_pos = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit so ptr+k never overflows before the modulo fold.
      w_pos = {1'b0, ptr_i} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(N)) begin
        w_pos = w_pos - (IW+1)'(N);
      end
      if (!any_o && req_i[w_pos[IW-1:0]]) begin
        any_o                 = 1'b1;
        idx_o                 = w_pos[IW-1:0];
        gnt_o[w_pos[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_share_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_share_arbiter : shares one byte FIFO between N_REQ writers and a reader
// Revision           : 1.0
// ============================================================================
module fifo_share_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_w,
  input  logic [N_REQ*DW-1:0]     w_data,
  output logic [N_REQ-1:0]        gnt_w,
  output logic [N_REQ-1:0]        rej_w,
  input  logic                    rd_req,
  output logic                    rd_valid,
  output logic [DW-1:0]           rd_data,
  output logic                    fifo_wen,
  output logic                    fifo_ren,
  output logic [DW-1:0]           fifo_din,
  input  logic [DW-1:0]           fifo_dout,
  input  logic                    fifo_error,
  output logic [CNT_W(DEPTH)-1:0] count,
  output logic                    proto_err
);

  localparam int CW = CNT_W(DEPTH);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] gnt_w_q, gnt_w_d;
  logic [N_REQ-1:0] rej_w_q, rej_w_d;
  logic             rd_valid_q, rd_valid_d;
  logic             fifo_wen_q, fifo_wen_d;
  logic             fifo_ren_q, fifo_ren_d;
  logic [DW-1:0]    fifo_din_q, fifo_din_d;
  logic [CW-1:0]    count_q, count_d;
  logic             proto_err_q, proto_err_d;
  logic             op_chk_q, op_chk_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  op_e              last_op_q, last_op_d;

  logic [N_REQ-1:0] w_req_eff;
  logic [N_REQ-1:0] w_win_oh;
  logic [IW-1:0]    w_win_idx;
  logic [IW-1:0]    w_rr_next;
  logic             w_any;
  logic [DW-1:0]    w_win_data;
  logic             w_rd_ok;
  logic             w_wr_ok;
  op_e              w_op;

  // A requester being pulsed this cycle has not yet had a chance to drop or
  // refresh its request, so it sits out one arbitration round.
  assign w_req_eff = req_w & ~(gnt_w_q | rej_w_q);

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req_i (w_req_eff),
    .ptr_i (rr_ptr_q),
    .gnt_o (w_win_oh),
    .idx_o (w_win_idx),
    .any_o (w_any)
  );

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_oh[i]) begin
        w_win_data = w_data[i*DW +: DW];
      end
    end
  end

  assign w_rr_next = (w_win_idx == IW'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  // fifo_ren_q doubles as rd_pending: no read is issued right behind another.
  assign w_rd_ok = rd_req && (count_q != '0) && !fifo_ren_q;
  assign w_wr_ok = w_any && (count_q < CW'(DEPTH));

  always_comb begin
    w_op = OP_IDLE;
    if (w_rd_ok && w_wr_ok) begin
      w_op = (last_op_q == OP_WRITE) ? OP_READ : OP_WRITE;
    end else if (w_rd_ok) begin
      w_op = OP_READ;
    end else if (w_wr_ok) begin
      w_op = OP_WRITE;
    end
  end

  always_comb begin
    gnt_w_d     = '0;
    rej_w_d     = '0;
    fifo_wen_d  = 1'b0;
    fifo_ren_d  = 1'b0;
    fifo_din_d  = '0;
    count_d     = count_q;
    rr_ptr_d    = rr_ptr_q;
    last_op_d   = last_op_q;
    rd_valid_d  = fifo_ren_q;
    op_chk_d    = fifo_wen_q | fifo_ren_q;
    proto_err_d = proto_err_q | (op_chk_q & fifo_error);

    case (w_op)
      OP_READ: begin
        fifo_ren_d = 1'b1;
        count_d    = count_q - 1'b1;
        last_op_d  = OP_READ;
      end
      OP_WRITE: begin
        rr_ptr_d = w_rr_next;
        if (w_win_data != '0) begin
          fifo_wen_d = 1'b1;
          fifo_din_d = w_win_data;
          gnt_w_d    = w_win_oh;
          count_d    = count_q + 1'b1;
          last_op_d  = OP_WRITE;
        end else begin
          rej_w_d = w_win_oh;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_w_q     <= '0;
      rej_w_q     <= '0;
      rd_valid_q  <= 1'b0;
      fifo_wen_q  <= 1'b0;
      fifo_ren_q  <= 1'b0;
      fifo_din_q  <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
      op_chk_q    <= 1'b0;
      rr_ptr_q    <= '0;
      last_op_q   <= OP_WRITE;
    end else begin
      gnt_w_q     <= gnt_w_d;
      rej_w_q     <= rej_w_d;
      rd_valid_q  <= rd_valid_d;
      fifo_wen_q  <= fifo_wen_d;
      fifo_ren_q  <= fifo_ren_d;
      fifo_din_q  <= fifo_din_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
      op_chk_q    <= op_chk_d;
      rr_ptr_q    <= rr_ptr_d;
      last_op_q   <= last_op_d;
    end
  end

  assign gnt_w     = gnt_w_q;
  assign rej_w     = rej_w_q;
  assign rd_valid  = rd_valid_q;
  assign fifo_wen  = fifo_wen_q;
  assign fifo_ren  = fifo_ren_q;
  assign fifo_din  = fifo_din_q;
  assign count     = count_q;
  assign proto_err = proto_err_q;

  // The FIFO's dout is already a register loaded by the ren edge; it is
  // passed through only during the valid pulse so rd_data idles at zero.
  assign rd_data = rd_valid_q ? fifo_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_fifo_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fifo_share_arbiter : scoreboard bench with a behavioural FIFO model
// Revision              : 1.0
// ============================================================================
module tb_fifo_share_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_w;
  logic [N*DW-1:0] w_data;
  logic            rd_req;
  logic [N-1:0]    gnt_w, rej_w;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic            fifo_wen, fifo_ren;
  logic [DW-1:0]   fifo_din, fifo_dout;
  logic            fifo_error;
  logic [CW-1:0]   count;
  logic            proto_err;

  always #5 clk = ~clk;

  fifo_share_arbiter #(.N_REQ(N), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_w      (req_w),
    .w_data     (w_data),
    .gnt_w      (gnt_w),
    .rej_w      (rej_w),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fifo_wen   (fifo_wen),
    .fifo_ren   (fifo_ren),
    .fifo_din   (fifo_din),
    .fifo_dout  (fifo_dout),
    .fifo_error (fifo_error),
    .count      (count),
    .proto_err  (proto_err)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]   exp_wr[$];
  logic [7:0]   exp_rd[$];
  logic [N-1:0] exp_gnt[$];
  logic [N-1:0] exp_rej[$];

  // Requester model: each requester walks its own list of bytes.
  logic [7:0] srcbuf[N][16];
  int         head[N];
  int         tail[N];

  // FIFO model: registered dout, error flag one cycle after a bad op.
  logic [7:0] fq[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_err = 1'b0;
  logic       force_err = 1'b0;

  assign fifo_dout  = m_dout;
  assign fifo_error = m_err | force_err;

  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
      m_dout <= 8'h00;
      m_err  <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (fifo_ren) begin
        if (fq.size() == 0) m_err <= 1'b1;
        else                m_dout <= fq.pop_front();
      end else if (fifo_wen) begin
        if (fq.size() >= DEPTH || fifo_din == 8'h00) m_err <= 1'b1;
        else                                       fq.push_back(fifo_din);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    check("wen_ren_exclusive", {31'b0, fifo_wen & fifo_ren}, 32'd0);
    if (fifo_wen === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wen: fifo_din=0x%0h, no write expected", fifo_din);
      end else check("fifo_din", {24'b0, fifo_din}, {24'b0, exp_wr.pop_front()});
    end
    if (rd_valid === 1'b1) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd_valid: rd_data=0x%0h, no read expected", rd_data);
      end else check("rd_data", {24'b0, rd_data}, {24'b0, exp_rd.pop_front()});
    end
    if (gnt_w !== '0 && !$isunknown(gnt_w)) begin
      if (exp_gnt.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_gnt: gnt_w=0x%0h, no grant expected", gnt_w);
      end else check("gnt_w", {28'b0, gnt_w}, {28'b0, exp_gnt.pop_front()});
    end
    if (rej_w !== '0 && !$isunknown(rej_w)) begin
      if (exp_rej.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rej: rej_w=0x%0h, no reject expected", rej_w);
      end else check("rej_w", {28'b0, rej_w}, {28'b0, exp_rej.pop_front()});
    end
  end

  task automatic push_src(input int i, input logic [7:0] d);
    srcbuf[i][tail[i]] = d;
    tail[i]++;
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if ((gnt_w[i] === 1'b1 || rej_w[i] === 1'b1) && tail[i] > head[i]) head[i]++;
      req_w[i]             = (tail[i] > head[i]);
      w_data[i*DW +: DW]   = (tail[i] > head[i]) ? srcbuf[i][head[i]] : 8'h00;
    end
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (count == CW'(target)) break;
    end
    check(name, 32'(count), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt_w"},     32'(gnt_w),     32'd0);
    check({tag, " rej_w"},     32'(rej_w),     32'd0);
    check({tag, " rd_valid"},  32'(rd_valid),  32'd0);
    check({tag, " rd_data"},   32'(rd_data),   32'd0);
    check({tag, " fifo_wen"},  32'(fifo_wen),  32'd0);
    check({tag, " fifo_ren"},  32'(fifo_ren),  32'd0);
    check({tag, " fifo_din"},  32'(fifo_din),  32'd0);
    check({tag, " count"},     32'(count),     32'd0);
    check({tag, " proto_err"}, 32'(proto_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    req_w  = '0;
    w_data = '0;
    rd_req = 1'b0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // 1: four requesters, round-robin order 0,1,2,3
    push_src(0, 8'h11); push_src(1, 8'h22); push_src(2, 8'h33); push_src(3, 8'h44);
    exp_wr.push_back(8'h11); exp_wr.push_back(8'h22);
    exp_wr.push_back(8'h33); exp_wr.push_back(8'h44);
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0010);
    exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b1000);
    tick();
    wait_count(4, 20, "t1 count");
    repeat (2) tick();
    check("t1 grants drained", 32'(exp_gnt.size()), 32'd0);

    // 2: fill to full, then writes stall
    push_src(0, 8'h55); push_src(0, 8'h66); push_src(0, 8'h77); push_src(0, 8'h88);
    exp_wr.push_back(8'h55); exp_wr.push_back(8'h66);
    exp_wr.push_back(8'h77); exp_wr.push_back(8'h88);
    repeat (4) exp_gnt.push_back(4'b0001);
    tick();
    wait_count(8, 30, "t2 count full");
    push_src(1, 8'h99);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t2 full no wen", 32'(fifo_wen), 32'd0);
      check("t2 full no gnt", 32'(gnt_w), 32'd0);
    end
    check("t2 count still full", 32'(count), 32'd8);
    exp_rd.push_back(8'h11);
    exp_wr.push_back(8'h99);
    exp_gnt.push_back(4'b0010);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("t2 ren issued", 32'(fifo_ren), 32'd1);
    check("t2 count after read", 32'(count), 32'd7);
    check("t2 rd_valid not yet", 32'(rd_valid), 32'd0);
    tick();
    check("t2 rd_valid latency", 32'(rd_valid), 32'd1);
    check("t2 first byte", 32'(rd_data), 32'h11);
    check("t2 refill count", 32'(count), 32'd8);

    // 3: drain to 4, then alternate write/read
    exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
    exp_rd.push_back(8'h44); exp_rd.push_back(8'h55);
    rd_req = 1'b1;
    wait_count(4, 20, "t3 drain to 4");
    rd_req = 1'b0;
    repeat (4) tick();
    push_src(2, 8'h5A); push_src(2, 8'h5B); push_src(2, 8'h5C);
    exp_wr.push_back(8'h5A); exp_wr.push_back(8'h5B); exp_wr.push_back(8'h5C);
    repeat (3) exp_gnt.push_back(4'b0100);
    exp_rd.push_back(8'h66); exp_rd.push_back(8'h77); exp_rd.push_back(8'h88);
    tick();
    rd_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t3 alt count", 32'(count), (k % 2 == 0) ? 32'd5 : 32'd4);
      check("t3 alt wen",   32'(fifo_wen), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    rd_req = 1'b0;
    repeat (4) tick();
    check("t3 count settled", 32'(count), 32'd4);

    // 4: zero data rejected; pointer advances past the rejected requester
    push_src(1, 8'h00);
    exp_rej.push_back(4'b0010);
    repeat (4) tick();
    check("t4 count unchanged", 32'(count), 32'd4);
    check("t4 reject seen", 32'(exp_rej.size()), 32'd0);
    push_src(2, 8'hB2); push_src(3, 8'hB3);
    exp_wr.push_back(8'hB2); exp_wr.push_back(8'hB3);
    exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b1000);
    tick();
    wait_count(6, 20, "t4 count after writes");

    // 5: drain to empty, reads stall, then a write unblocks a read
    exp_rd.push_back(8'h99); exp_rd.push_back(8'h5A); exp_rd.push_back(8'h5B);
    exp_rd.push_back(8'h5C); exp_rd.push_back(8'hB2); exp_rd.push_back(8'hB3);
    rd_req = 1'b1;
    wait_count(0, 30, "t5 drain to empty");
    rd_req = 1'b0;
    repeat (4) tick();
    rd_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5 empty no ren", 32'(fifo_ren), 32'd0);
      check("t5 empty no valid", 32'(rd_valid), 32'd0);
    end
    push_src(0, 8'h7A);
    exp_wr.push_back(8'h7A);
    exp_gnt.push_back(4'b0001);
    exp_rd.push_back(8'h7A);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (rd_valid === 1'b1) seen = 1'b1;
    end
    rd_req = 1'b0;
    check("t5 read after write", 32'(seen), 32'd1);
    check("t5 data 7A", 32'(rd_data), 32'h7A);
    tick();
    check("t5 count empty", 32'(count), 32'd0);
    check("t5 no proto_err", 32'(proto_err), 32'd0);

    // 6: reset mid-burst with a read in flight
    push_src(0, 8'hC1); push_src(0, 8'hC2); push_src(0, 8'hC3);
    push_src(0, 8'hC4); push_src(0, 8'hC5);
    exp_wr.push_back(8'hC1); exp_wr.push_back(8'hC2); exp_wr.push_back(8'hC3);
    exp_wr.push_back(8'hC4); exp_wr.push_back(8'hC5);
    repeat (5) exp_gnt.push_back(4'b0001);
    tick();
    wait_count(5, 30, "t6 count 5");
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("t6 ren in flight", 32'(fifo_ren), 32'd1);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    tick();
    check_all_zero("t6 mid reset");
    rst_n = 1'b1;
    tick();
    check("t6 no rd_valid after reset", 32'(rd_valid), 32'd0);

    // 6b: unpredicted FIFO error after a legal write is sticky
    push_src(3, 8'hD1);
    exp_wr.push_back(8'hD1);
    exp_gnt.push_back(4'b1000);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (fifo_wen === 1'b1) seen = 1'b1;
    end
    check("t6 write issued", 32'(seen), 32'd1);
    force_err = 1'b1;
    tick();
    check("t6 proto_err not yet", 32'(proto_err), 32'd0);
    tick();
    force_err = 1'b0;
    check("t6 proto_err set", 32'(proto_err), 32'd1);
    repeat (5) tick();
    check("t6 proto_err sticky", 32'(proto_err), 32'd1);
    check("t6 count after write", 32'(count), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6 proto_err cleared", 32'(proto_err), 32'd0);
    rst_n = 1'b1;
    tick();

    check("end exp_wr empty",  32'(exp_wr.size()),  32'd0);
    check("end exp_rd empty",  32'(exp_rd.size()),  32'd0);
    check("end exp_gnt empty", 32'(exp_gnt.size()), 32'd0);
    check("end exp_rej empty", 32'(exp_rej.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
